// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared arbiter state type and requester/strobe constants
package axi4_lite_pkg;
    localparam int NUM_REQ    = 2;
    localparam int STRB_WIDTH = 4;
    typedef enum logic [1:0] {IDLE, START, WAIT} arb_state_e;
endpackage

// File: rtl/axi4_lite_write_arbiter_if.sv
// axi4_lite_write_arbiter_if: requester, write-master and status signals of the write arbiter
interface axi4_lite_write_arbiter_if
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_data0;
    logic [DATA_WIDTH-1:0] req_data1;
    logic [STRB_WIDTH-1:0] req_strb0;
    logic [STRB_WIDTH-1:0] req_strb1;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    req_done;
    logic                  write_start;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [STRB_WIDTH-1:0] write_strobe;
    logic                  master_busy;
    logic                  master_rst;
    logic                  timeout_err;
    logic                  timeout_clr;
    modport master (
        input  req_valid, req_addr0, req_addr1, req_data0, req_data1, req_strb0, req_strb1,
        input  master_busy, timeout_clr,
        output req_ack, req_done, write_start, write_addr, write_data, write_strobe,
        output master_rst, timeout_err
    );
    modport slave (
        output req_valid, req_addr0, req_addr1, req_data0, req_data1, req_strb0, req_strb1,
        output master_busy, timeout_clr,
        input  req_ack, req_done, write_start, write_addr, write_data, write_strobe,
        input  master_rst, timeout_err
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with last-grant history
module rr_arbiter2
    import axi4_lite_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic               gnt
);
    logic last_grant;
    // Resetting history to 1 hands the first tie to requester 0.
    assign gnt = &req ? ~last_grant : req[1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_grant <= 1'b1;
        else if (take) last_grant <= gnt;
    end
endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// axi4_lite_write_arbiter: round-robin arbitration of two write requesters onto one
// AXI4-Lite write master, with a sticky timeout on long master busy periods
module axi4_lite_write_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
)(
    input logic                       clk,
    input logic                       rst,
    axi4_lite_write_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    arb_state_e            state, state_nxt;
    logic                  grant, gnt, take, to_set;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [STRB_WIDTH-1:0] sel_strb;
    assign take           = state == IDLE && |bus.req_valid;
    assign sel_addr       = grant ? bus.req_addr1 : bus.req_addr0;
    assign sel_data       = grant ? bus.req_data1 : bus.req_data0;
    assign sel_strb       = grant ? bus.req_strb1 : bus.req_strb0;
    assign bus.master_rst = ~rst;
    // Fires once, on the WAIT cycle that brings the count up to the limit.
    assign to_set = state == WAIT && bus.master_busy && cnt == CW'(TIMEOUT_CYCLES - 1);
    rr_arbiter2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  (bus.req_valid),
        .take (take),
        .gnt  (gnt)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            grant           <= 1'b0;
            cnt             <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) grant <= gnt;
            if (state == START) cnt <= '0;
            else if (state == WAIT && cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
            if (to_set) bus.timeout_err <= 1'b1;
            else if (bus.timeout_clr) bus.timeout_err <= 1'b0;
        end
    end
    always_comb begin
        state_nxt        = state;
        bus.req_ack      = '0;
        bus.req_done     = '0;
        bus.write_start  = 1'b0;
        bus.write_addr   = '0;
        bus.write_data   = '0;
        bus.write_strobe = '0;
        case (state)
            IDLE: state_nxt = |bus.req_valid ? START : IDLE;
            START: begin
                state_nxt          = WAIT;
                bus.write_start    = 1'b1;
                bus.req_ack[grant] = 1'b1;
                bus.write_addr     = sel_addr;
                bus.write_data     = sel_data;
                bus.write_strobe   = sel_strb;
            end
            WAIT: begin
                state_nxt           = bus.master_busy ? WAIT : IDLE;
                bus.req_done[grant] = ~bus.master_busy;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// tb_axi4_lite_write_arbiter: directed checks of the write arbiter against a behavioural
// write master whose AW/W acceptance delay and B response can be stalled
module tb_axi4_lite_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    axi4_lite_write_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    axi4_lite_write_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    int   aw_wait   = 0;
    logic bvalid_en = 1'b1;
    logic busy = 1'b0, in_aw = 1'b0, in_b = 1'b0;
    int   aw_cnt = 0;
    assign bus.master_busy = busy;
    // Busy rises the cycle after write_start; AW/W takes aw_wait+1 cycles, then B when allowed.
    always @(posedge clk or posedge bus.master_rst) begin
        if (bus.master_rst) begin
            busy  <= 1'b0;
            in_aw <= 1'b0;
            in_b  <= 1'b0;
        end else if (bus.write_start) begin
            busy   <= 1'b1;
            in_aw  <= 1'b1;
            aw_cnt <= aw_wait;
        end else if (in_aw) begin
            if (aw_cnt == 0) begin
                in_aw <= 1'b0;
                in_b  <= 1'b1;
            end else aw_cnt <= aw_cnt - 1;
        end else if (in_b && bvalid_en) begin
            in_b <= 1'b0;
            busy <= 1'b0;
        end
    end
    int ack0 = 0, ack1 = 0, done0 = 0, done1 = 0, starts = 0, multi = 0;
    always @(negedge clk) begin
        ack0   <= ack0 + int'(bus.req_ack[0]);
        ack1   <= ack1 + int'(bus.req_ack[1]);
        done0  <= done0 + int'(bus.req_done[0]);
        done1  <= done1 + int'(bus.req_done[1]);
        starts <= starts + int'(bus.write_start);
        multi  <= multi + int'(&bus.req_ack) + int'(&bus.req_done);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ack(output int cyc);
        cyc = 0;
        while (bus.req_ack == 2'b00 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.req_done == 2'b00 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask
    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask
    initial begin
        int cyc, snap, s0;
        logic idx;
        bus.req_valid   = 2'b00;
        bus.req_addr0   = '0;
        bus.req_addr1   = '0;
        bus.req_data0   = '0;
        bus.req_data1   = '0;
        bus.req_strb0   = '0;
        bus.req_strb1   = '0;
        bus.timeout_clr = 1'b0;
        repeat (3) tick();
        check("rst_ack", bus.req_ack, 2'b00);
        check("rst_done", bus.req_done, 2'b00);
        check("rst_start", bus.write_start, 1'b0);
        check("rst_addr", bus.write_addr, 32'h0);
        check("rst_err", bus.timeout_err, 1'b0);
        check("rst_master_rst", bus.master_rst, 1'b1);
        rst = 1'b1;
        tick();
        check("run_master_rst", bus.master_rst, 1'b0);
        // single zero-wait write from requester 0
        bus.req_addr0 = 32'h1000_0004;
        bus.req_data0 = 32'hDEAD_BEEF;
        bus.req_strb0 = 4'hF;
        bus.req_valid = 2'b01;
        tick();
        check("single_ack", bus.req_ack, 2'b01);
        check("single_start", bus.write_start, 1'b1);
        check("single_addr", bus.write_addr, 32'h1000_0004);
        check("single_data", bus.write_data, 32'hDEAD_BEEF);
        check("single_strb", bus.write_strobe, 4'hF);
        bus.req_valid = 2'b00;
        tick();
        check("single_n2_start", bus.write_start, 1'b0);
        check("single_n2_addr", bus.write_addr, 32'h0);
        check("single_n2_data", bus.write_data, 32'h0);
        check("single_n2_ack", bus.req_ack, 2'b00);
        tick();
        check("single_n3_done", bus.req_done, 2'b00);
        tick();
        check("single_n4_done", bus.req_done, 2'b01);
        tick();
        check("single_n5_done", bus.req_done, 2'b00);
        check("single_err", bus.timeout_err, 1'b0);
        // contention from reset: 0,1,0,1
        do_reset();
        bus.req_data0 = 32'hAAAA_0000;
        bus.req_data1 = 32'hBBBB_1111;
        bus.req_addr1 = 32'h2000_0008;
        bus.req_strb1 = 4'h3;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(cyc);
            check($sformatf("rr_ack_lat%0d", i), cyc, (i == 0) ? 1 : 2);
            idx = bus.req_ack[1];
            check($sformatf("rr_order%0d", i), idx, i % 2);
            check($sformatf("rr_data%0d", i), bus.write_data, (i % 2) ? 32'hBBBB_1111 : 32'hAAAA_0000);
            wait_done(cyc);
            check($sformatf("rr_done_lat%0d", i), cyc, 3);
            check($sformatf("rr_done_idx%0d", i), bus.req_done, (i % 2) ? 2'b10 : 2'b01);
        end
        bus.req_valid = 2'b00;
        tick();
        tick();
        check("rr_idle_ack", bus.req_ack, 2'b00);
        // slave stalls AW/W for 10 cycles
        aw_wait = 10;
        s0 = starts;
        bus.req_valid = 2'b01;
        wait_ack(cyc);
        check("delay_ack_lat", cyc, 1);
        bus.req_valid = 2'b00;
        wait_done(cyc);
        check("delay_done_lat", cyc, 13);
        check("delay_done_idx", bus.req_done, 2'b01);
        check("delay_starts", starts - s0, 1);
        check("delay_err", bus.timeout_err, 1'b1);
        aw_wait = 0;
        bus.timeout_clr = 1'b1;
        tick();
        bus.timeout_clr = 1'b0;
        check("delay_clr", bus.timeout_err, 1'b0);
        // B withheld: timeout after 8 WAIT cycles, clear held across the setting edge
        bvalid_en = 1'b0;
        bus.req_valid = 2'b10;
        wait_ack(cyc);
        check("to_ack_lat", cyc, 1);
        check("to_ack_idx", bus.req_ack, 2'b10);
        bus.req_valid = 2'b00;
        snap = done1;
        repeat (6) tick();
        bus.timeout_clr = 1'b1;
        tick();
        check("to_n8_err", bus.timeout_err, 1'b0);
        tick();
        check("to_n9_err", bus.timeout_err, 1'b0);
        tick();
        check("to_n10_err", bus.timeout_err, 1'b1);
        bus.timeout_clr = 1'b0;
        repeat (5) tick();
        check("to_no_done", done1 - snap, 0);
        bvalid_en = 1'b1;
        wait_done(cyc);
        check("to_done_lat", cyc, 1);
        check("to_done_idx", bus.req_done, 2'b10);
        check("to_err_sticky", bus.timeout_err, 1'b1);
        bus.timeout_clr = 1'b1;
        tick();
        bus.timeout_clr = 1'b0;
        check("to_clr", bus.timeout_err, 1'b0);
        // reset while requester 1 is in WAIT
        bvalid_en = 1'b0;
        bus.req_valid = 2'b10;
        wait_ack(cyc);
        check("mr_ack_idx", bus.req_ack, 2'b10);
        bus.req_valid = 2'b00;
        tick();
        tick();
        snap = done1;
        rst = 1'b0;
        #1;
        check("mr_ack", bus.req_ack, 2'b00);
        check("mr_done", bus.req_done, 2'b00);
        check("mr_start", bus.write_start, 1'b0);
        check("mr_addr", bus.write_addr, 32'h0);
        check("mr_err", bus.timeout_err, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        bvalid_en = 1'b1;
        repeat (4) tick();
        check("mr_no_done", done1 - snap, 0);
        bus.req_valid = 2'b11;
        wait_ack(cyc);
        check("mr_tie_idx", bus.req_ack, 2'b01);
        bus.req_valid = 2'b00;
        wait_done(cyc);
        check("mr_done_lat", cyc, 3);
        tick();
        // requester 1 withdraws before it can be acknowledged
        aw_wait = 4;
        bus.req_valid = 2'b01;
        wait_ack(cyc);
        check("wd_ack_idx", bus.req_ack, 2'b01);
        snap = ack1;
        bus.req_valid = 2'b00;
        tick();
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        wait_done(cyc);
        check("wd_done_idx", bus.req_done, 2'b01);
        repeat (5) tick();
        check("wd_no_ack1", ack1 - snap, 0);
        aw_wait = 0;
        check("onehot", multi, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_lite_write_arbiter.md
AXI4_LITE_WRITE_ARBITER -- requirements
Module: axi4_lite_write_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; TIMEOUT_CYCLES, default 256, WAIT-state cycle limit before flagging a timeout.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester write request, index 0/1.
REQ-005 req_addr0/req_addr1  input  ADDR_WIDTH  per-requester write address.
REQ-006 req_data0/req_data1  input  DATA_WIDTH  per-requester write data.
REQ-007 req_strb0/req_strb1  input  4  per-requester byte strobes.
REQ-008 req_ack  output  2  one-cycle pulse, request accepted and launched.
REQ-009 req_done  output  2  one-cycle pulse, launched write completed (B response received).
REQ-010 write_start  output  1  launch pulse to the AXI4-Lite write master.
REQ-011 write_addr/write_data/write_strobe  output  ADDR_WIDTH/DATA_WIDTH/4  payload to the write master.
REQ-012 master_busy  input  1  busy flag from the write master.
REQ-013 timeout_err  output  1  sticky flag, WAIT exceeded TIMEOUT_CYCLES.
REQ-014 timeout_clr  input  1  synchronous clear of timeout_err.

Function
REQ-015 FSM states SHALL be IDLE, START and WAIT.
REQ-016 IDLE: any req_valid bit set -> latch grant index -> START; otherwise stay.
REQ-017 Arbitration SHALL be round-robin: single valid wins; both valid -> the index not equal to last_grant wins; last_grant updates on each grant.
REQ-018 START lasts exactly one cycle: write_start=1, req_ack[grant]=1, payload driven from the granted requester; then -> WAIT.
REQ-019 Outside START, write_start=0 and write_addr/write_data/write_strobe are driven to 0.
REQ-020 WAIT: master_busy=0 -> req_done[grant]=1 combinationally in that cycle, -> IDLE; master_busy=1 -> stay.
REQ-021 START is followed by WAIT without sampling busy; the master raises busy the cycle after write_start, so WAIT first samples a valid busy.
REQ-022 Latency: req_valid sampled in IDLE at cycle N -> ack at N+1 -> done no earlier than N+4 (zero-wait slave).
REQ-023 Requesters SHALL hold req_valid and payload stable until req_ack; the arbiter does not check stability.
REQ-024 A request held after ack is treated as a new request; it is not granted before the current req_done.
REQ-025 req_valid deasserted before ack -> the request is dropped silently, with no ack.
REQ-026 Timeout counter clears on entry to WAIT, increments each WAIT cycle, and saturates.
REQ-027 Count reaching TIMEOUT_CYCLES sets timeout_err; the FSM keeps waiting and does not abort the master.
REQ-028 timeout_clr and a timeout set in the same cycle -> set wins.
REQ-029 At most one bit of req_ack and of req_done SHALL be set in any cycle.

Reset
REQ-030 rst low SHALL force state=IDLE, last_grant=1, grant=0, counter=0, timeout_err=0, and all outputs to 0, asynchronously.
REQ-031 rst low mid-operation abandons the in-flight write with no req_done.
REQ-032 The top level SHALL reset the write master in the same cycle, by inversion onto its active-high reset.
REQ-033 First tie after reset SHALL go to requester 0.

Structure
REQ-034 Shared package axi4_lite_pkg SHALL hold the arbiter state typedef, requester count (2), and the strobe width constant (4).
REQ-035 One sub-module, rr_arbiter2, SHALL implement the 2-way round-robin grant and last_grant register; everything else stays in this module.

Verification
REQ-036 Single write: req_valid=01, addr0=0x1000_0004, data0=0xDEAD_BEEF, strb0=0xF, zero-wait slave -> ack[0] at N+1, AW/W carry those values, done[0] at N+4.
REQ-037 Contention: req_valid=11 held for four transactions -> grant order 0,1,0,1, each done before the next ack.
REQ-038 Slave delay: AWREADY/WREADY held low 10 cycles -> ack once, done 10 cycles later than the zero-wait case, no second write_start.
REQ-039 Timeout: TIMEOUT_CYCLES=8, BVALID withheld -> timeout_err=1 after 8 WAIT cycles, no done; later BVALID -> done; timeout_clr -> flag 0.
REQ-040 Reset mid-WAIT: rst low for 2 cycles while requester 1 is in flight -> no done[1], all outputs 0, next tie granted to 0.
REQ-041 Withdrawn request: req_valid[1] pulsed for one cycle while requester 0 is in WAIT -> no ack[1] ever.
